// File: rtl/unpack_s6_s32.sv
// Purpose: unpack a word of LANES signed 6-bit lanes into a stream of sign-extended, left-shifted 32-bit elements.
// Latency: first element is valid the cycle after the word is accepted; one element per cycle thereafter.
// Backpressure: out_ready low holds the current element; in_ready rises only as the last lane leaves (no bubble).
module unpack_s6_s32 #(
    parameter int LANES = 5,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*LANES-1:0]   in_data,
    input  logic [2:0]           in_count,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [2:0] LANES_3 = 3'(LANES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [6*LANES-1:0]   r_data;
    logic [2:0]           r_cnt;
    logic [2:0]           r_idx;

    logic [2:0]           w_eff_cnt;
    logic                 w_is_last;
    logic                 w_load;
    logic                 w_adv;
    logic [5:0]           w_lane;
    logic [31:0]          w_ext;
    logic [31:0]          w_shifted;

    // Clamp the lane count: zero or out-of-range counts mean a full word.
    always_comb begin
        w_eff_cnt = in_count;
        if (in_count == 3'd0 || in_count > LANES_3) begin
            w_eff_cnt = LANES_3;
        end
    end

    // Select the current lane, sign-extend it and apply the dequant shift.
    always_comb begin
        w_lane = r_data[5:0];
        for (int k = 0; k < LANES; k++) begin
            if (r_idx == 3'(k)) begin
                w_lane = r_data[6*k +: 6];
            end
        end
        w_ext     = {{26{w_lane[5]}}, w_lane};
        w_shifted = w_ext << SHIFT;
        w_is_last = (r_idx == (r_cnt - 3'd1));
    end

    // Next-state and handshake outputs; reset masks every output to zero.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = 32'd0;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = EMIT;
                    end
                end
                EMIT: begin
                    out_valid = 1'b1;
                    out_last  = w_is_last;
                    out_data  = w_shifted;
                    if (out_ready) begin
                        if (w_is_last) begin
                            // Last lane leaving: a new word may slot in with no bubble.
                            in_ready = 1'b1;
                            if (in_valid) begin
                                w_load      = 1'b1;
                                w_state_nxt = EMIT;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_adv = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, held word, count and lane index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= 3'd0;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_data <= in_data;
                r_cnt  <= w_eff_cnt;
                r_idx  <= 3'd0;
            end else if (w_adv) begin
                r_idx  <= r_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_unpack_s6_s32.sv
// Purpose: scoreboard bench for unpack_s6_s32 (default instance plus a SHIFT=26 instance).
// Latency: expectations are queued on word acceptance and retired on each output transfer.
// Backpressure: out_ready is driven high, in a 1,0,0,1 pattern, or randomly.
module tb_unpack_s6_s32;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_data;
    logic [2:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    logic        b_valid;
    logic        b_ready;
    logic [11:0] b_data;
    logic [2:0]  b_count;
    logic        b_ovalid;
    logic        b_oready;
    logic [31:0] b_odata;
    logic        b_olast;

    int n_total = 0;
    int n_bad   = 0;
    int pops    = 0;
    int stall_mode = 0;
    int pidx    = 0;
    logic [3:0] stall_pat = 4'b1001;

    exp_t q[$];
    logic        hold;
    logic [31:0] hold_d;
    logic        hold_l;
    exp_t        cur;

    always #5 clk = ~clk;

    unpack_s6_s32 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    unpack_s6_s32 #(.LANES(2), .SHIFT(26)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data), .in_count(b_count),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata), .out_last(b_olast)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer backpressure, updated on the falling edge.
    always @(negedge clk) begin
        if (stall_mode == 1) begin
            out_ready = stall_pat[pidx % 4];
            pidx++;
        end else if (stall_mode == 2) begin
            out_ready = 1'($urandom_range(0, 1));
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: retires expectations and checks handshake behaviour.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid) begin
                if (hold) begin
                    chk("hold_data", out_data, hold_d);
                    chk("hold_last", 32'(out_last), 32'(hold_l));
                end
                if (q.size() > 0) begin
                    cur = q[0];
                    chk("in_ready_emit", 32'(in_ready), 32'(out_ready && cur.l));
                    if (out_ready) begin
                        chk("data", out_data, cur.d);
                        chk("last", 32'(out_last), 32'(cur.l));
                        void'(q.pop_front());
                        pops++;
                    end
                end
                hold   = !out_ready;
                hold_d = out_data;
                hold_l = out_last;
            end else begin
                chk("in_ready_idle", 32'(in_ready), 32'd1);
                hold = 1'b0;
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic send(input logic [29:0] d, input logic [2:0] c);
        int   g;
        int   n;
        int   sv;
        logic [5:0] v;
        exp_t e;
        @(negedge clk);
        in_data  = d;
        in_count = c;
        in_valid = 1'b1;
        #2;
        g = 0;
        while (!in_ready) begin
            @(negedge clk);
            #2;
            g++;
            if (g > 200) begin
                chk("in_ready_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        n = (c == 3'd0 || c > 3'd5) ? 5 : int'(c);
        for (int k = 0; k < n; k++) begin
            v  = d[6*k +: 6];
            sv = v[5] ? int'(v) - 64 : int'(v);
            e.d = 32'(sv);
            e.l = (k == n - 1);
            q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        in_data  = 30'h2AAAAAAA;
        in_count = 3'd3;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 400) begin
            @(negedge clk);
            #4;
            g++;
        end
        if (g >= 400) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int base;
        int g;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_count = 3'd0;
        out_ready = 1'b1;
        b_valid  = 1'b0;
        b_data   = '0;
        b_count  = 3'd0;
        b_oready = 1'b1;
        hold     = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #4;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single word with mixed signs.
        send({6'h00, 6'h1F, 6'h20, 6'h3F, 6'h01}, 3'd5);
        drain();

        // Two back-to-back words.
        send({6'h05, 6'h04, 6'h03, 6'h02, 6'h01}, 3'd5);
        send({6'h3A, 6'h3B, 6'h3C, 6'h3D, 6'h3E}, 3'd5);
        drain();

        // Short word, then count 0 and count 7 meaning full word.
        send({6'h11, 6'h12, 6'h13, 6'h2F, 6'h0A}, 3'd2);
        send({6'h21, 6'h22, 6'h23, 6'h24, 6'h25}, 3'd0);
        send({6'h31, 6'h0E, 6'h33, 6'h07, 6'h35}, 3'd7);
        drain();

        // Stalled consumer 1,0,0,1.
        stall_mode = 1;
        pidx = 0;
        send({6'h19, 6'h28, 6'h37, 6'h06, 6'h15}, 3'd5);
        send({6'h01, 6'h02, 6'h03, 6'h04, 6'h05}, 3'd3);
        drain();
        stall_mode = 0;

        // SHIFT 26 extremes on the second instance.
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = {6'h1F, 6'h20};
        b_count = 3'd2;
        #2;
        chk("b_in_ready", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        @(negedge clk);
        #2;
        chk("b_valid0", 32'(b_ovalid), 32'd1);
        chk("b_data0", b_odata, 32'h80000000);
        chk("b_last0", 32'(b_olast), 32'd0);
        @(negedge clk);
        #2;
        chk("b_data1", b_odata, 32'h7C000000);
        chk("b_last1", 32'(b_olast), 32'd1);
        @(negedge clk);
        #2;
        chk("b_valid_end", 32'(b_ovalid), 32'd0);

        // Reset after the second lane of a five-lane word.
        base = pops;
        send({6'h0F, 6'h0E, 6'h0D, 6'h0C, 6'h0B}, 3'd5);
        g = 0;
        while (pops < base + 2 && g < 100) begin
            @(negedge clk);
            #4;
            g++;
        end
        if (g >= 100) chk("mid_rst_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        #4;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        #4;
        chk("mid_rst_valid2", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        send({6'h3F, 6'h3E, 6'h3D, 6'h3C, 6'h3B}, 3'd5);
        drain();

        // Random words under random backpressure.
        stall_mode = 2;
        for (int i = 0; i < 12; i++) begin
            send(30'($urandom), 3'($urandom_range(0, 7)));
        end
        drain();
        stall_mode = 0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unpack_s6_s32.md
UNPACK_S6_S32 -- requirements
Module: unpack_s6_s32

Interface
REQ-001 SHALL have parameter LANES, default 5: number of 6-bit signed lanes per packed input word, legal range 1..5.
REQ-002 SHALL have parameter SHIFT, default 0: left shift applied after sign extension (dequant scale), legal range 0..26.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a packed word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-007 SHALL have port in_data, input, 6*LANES bits: packed lanes, lane 0 in bits [5:0], lane k in bits [6k+5:6k].
REQ-008 SHALL have port in_count, input, 3 bits: number of valid lanes in the word; values 0 or greater than LANES are treated as LANES.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the element this cycle.
REQ-011 SHALL have port out_data, output, 32 bits: signed, sign-extended, shifted lane value.
REQ-012 SHALL have port out_last, output, 1 bit: out_data is the final valid lane of its word.

Function
REQ-013 SHALL transfer an input word on a clk edge where in_valid and in_ready are both 1, and an output element on a clk edge where out_valid and out_ready are both 1.
REQ-014 SHALL implement two states: IDLE (no word held) and EMIT (word held, lane index idx, count cnt).
REQ-015 SHALL assert in_ready in IDLE, and in EMIT only when the last lane is being transferred out that cycle (out_valid, out_ready, idx == cnt-1).
REQ-016 On input transfer, SHALL register in_data and the effective count, set idx to 0, and enter or stay in EMIT; out_valid SHALL be 1 the cycle after acceptance (latency 1).
REQ-017 In EMIT, SHALL drive out_data = sign_extend_32(lane[idx]) << SHIFT, with arithmetic sign preserved; a value of -32 with SHIFT 26 SHALL yield 0x80000000 (no overflow exists in the legal range).
REQ-018 SHALL drive out_last = 1 exactly when idx == cnt-1 in EMIT.
REQ-019 On output transfer with idx < cnt-1, SHALL increment idx.
REQ-020 On output transfer of the last lane: with a simultaneous input transfer, SHALL load the new word and stay in EMIT with no bubble; otherwise SHALL return to IDLE with out_valid 0 the next cycle.
REQ-021 While out_valid is 1 and out_ready is 0, SHALL hold out_data, out_last and idx stable.
REQ-022 SHALL ignore in_data and in_count on cycles without an input transfer.
REQ-023 SHALL sustain one element per cycle when out_ready is held at 1 and words arrive back-to-back.

Reset
REQ-024 While rst is 1, SHALL force IDLE, idx 0, out_valid 0, out_last 0, out_data 0, in_ready 0.
REQ-025 A rst asserted mid-word SHALL discard the held word and its remaining lanes; no partial lanes are emitted after release.
REQ-026 On the first cycle after rst deasserts, SHALL present in_ready 1.

Verification
REQ-027 Word with lanes 0x01,0x3F,0x20,0x1F,0x00, in_count 5, SHIFT 0, out_ready 1 -> out_data 1, -1, -32, 31, 0 on five consecutive cycles, out_last only on the fifth.
REQ-028 Two words back-to-back, in_count 5 each, out_ready 1 -> ten consecutive valid outputs with no bubble; in_ready 1 on the fifth output cycle only.
REQ-029 in_count 2, then in_count 0 -> two outputs with out_last on the second, then five outputs.
REQ-030 out_ready toggled 1,0,0,1 during emission -> each element held for stall cycles and emitted exactly once, order preserved.
REQ-031 SHIFT 26, lanes 0x20 and 0x1F -> out_data 0x80000000 then 0x7C000000.
REQ-032 rst pulsed after second lane of a five-lane word -> out_valid 0 during and after reset; the next accepted word emits from its lane 0.
